v_instr_queue: RTL and testbench

V_INSTR_QUEUE -- requirements
Module: v_instr_queue

---
 rtl/v_instr_queue.sv | 154 +++++++++++++++
 tb/tb_v_instr_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_instr_queue.sv
// Instruction queue in front of the vector decoder: a first-word-fall-through
// circular FIFO with a fence that stalls issue until a vset* commit is acknowledged.
module v_instr_queue #(
  parameter int DEPTH          = 4,
  parameter int INSTR_WIDTH    = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TRACK_ID_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTR_WIDTH-1:0]        in_instr,
  input  logic [DATA_WIDTH-1:0]         in_rs1,
  input  logic [DATA_WIDTH-1:0]         in_rs2,
  input  logic [TRACK_ID_WIDTH-1:0]     in_track_id,
  input  logic [2:0]                    in_vxrm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSTR_WIDTH-1:0]        out_instr,
  output logic [DATA_WIDTH-1:0]         out_rs1,
  output logic [DATA_WIDTH-1:0]         out_rs2,
  output logic [TRACK_ID_WIDTH-1:0]     out_track_id,
  output logic [2:0]                    out_vxrm,
  input  logic                          vcfg_ack,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_CFG = 1'b1
  } state_t;

  // vset* encoding: OP-V major opcode with the OPCFG funct3
  function automatic logic is_cfg(input logic [INSTR_WIDTH-1:0] instr);
    return (instr[6:0] == 7'b1010111) && (instr[14:12] == 3'b111);
  endfunction

  logic [INSTR_WIDTH-1:0]    r_instr    [DEPTH];
  logic [DATA_WIDTH-1:0]     r_rs1      [DEPTH];
  logic [DATA_WIDTH-1:0]     r_rs2      [DEPTH];
  logic [TRACK_ID_WIDTH-1:0] r_track_id [DEPTH];
  logic [2:0]                r_vxrm     [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_nxt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_cfg_pending;

  assign w_full        = (r_count == CW'(DEPTH));
  assign w_empty       = (r_count == {CW{1'b0}});
  assign w_cfg_pending = (r_state == ST_WAIT_CFG);

  // Outputs are forced to their reset values while rst is low, before the first edge lands
  assign in_ready  = rst ? (~w_full & ~flush) : ~flush;
  assign out_valid = rst & ~w_empty & ~w_cfg_pending & ~flush;
  assign count     = rst ? r_count : {CW{1'b0}};

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  assign out_instr    = r_instr[r_rd_ptr];
  assign out_rs1      = r_rs1[r_rd_ptr];
  assign out_rs2      = r_rs2[r_rd_ptr];
  assign out_track_id = r_track_id[r_rd_ptr];
  assign out_vxrm     = r_vxrm[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i]    <= {INSTR_WIDTH{1'b0}};
        r_rs1[i]      <= {DATA_WIDTH{1'b0}};
        r_rs2[i]      <= {DATA_WIDTH{1'b0}};
        r_track_id[i] <= {TRACK_ID_WIDTH{1'b0}};
        r_vxrm[i]     <= 3'b000;
      end
    end else if (w_push) begin
      r_instr[r_wr_ptr]    <= in_instr;
      r_rs1[r_wr_ptr]      <= in_rs1;
      r_rs2[r_wr_ptr]      <= in_rs2;
      r_track_id[r_wr_ptr] <= in_track_id;
      r_vxrm[r_wr_ptr]     <= in_vxrm;
    end
  end

  // Flush beats push/pop; in_ready/out_valid are already low then, this just zeroes state
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A popped config entry wins over a same-cycle ack so the new fence is not lost
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop && is_cfg(out_instr)) begin
            w_state_nxt = ST_WAIT_CFG;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WAIT_CFG: begin
          if (w_pop && is_cfg(out_instr)) begin
            w_state_nxt = ST_WAIT_CFG;
          end else if (vcfg_ack) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT_CFG;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v_instr_queue.sv
// Directed bench for v_instr_queue: stimulus pushes expected entries into a
// scoreboard queue, an independent monitor compares every popped entry.
module tb_v_instr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [3:0]  in_track_id;
  logic [2:0]  in_vxrm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_rs1;
  logic [31:0] out_rs2;
  logic [3:0]  out_track_id;
  logic [2:0]  out_vxrm;
  logic        vcfg_ack;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  tid;
    logic [2:0]  vxrm;
  } ent_t;

  ent_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  v_instr_queue #(.DEPTH(4), .INSTR_WIDTH(32), .DATA_WIDTH(32), .TRACK_ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_track_id(in_track_id), .in_vxrm(in_vxrm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_track_id(out_track_id), .out_vxrm(out_vxrm),
    .vcfg_ack(vcfg_ack), .count(count)
  );

  always #5 clk = ~clk;

  // Payload fields derived from the instruction so every field is distinct per entry
  function automatic ent_t mk(input logic [31:0] instr);
    ent_t e;
    e.instr = instr;
    e.rs1   = instr ^ 32'hDEAD_BEEF;
    e.rs2   = {instr[15:0], instr[31:16]} + 32'h0000_1234;
    e.tid   = instr[23:20] ^ 4'h5;
    e.vxrm  = instr[22:20] ^ 3'b010;
    return e;
  endfunction

  task automatic offer(input logic [31:0] instr);
    ent_t e;
    e = mk(instr);
    in_valid    = 1'b1;
    in_instr    = e.instr;
    in_rs1      = e.rs1;
    in_rs2      = e.rs2;
    in_track_id = e.tid;
    in_vxrm     = e.vxrm;
  endtask

  task automatic push(input logic [31:0] instr);
    offer(instr);
    exp_q.push_back(mk(instr));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got instr %h, required no pop at %0t", out_instr, $time);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        if (out_instr !== e.instr || out_rs1 !== e.rs1 || out_rs2 !== e.rs2 ||
            out_track_id !== e.tid || out_vxrm !== e.vxrm) begin
          fails++;
          $display("FAIL pop_payload: got %h/%h/%h/%h/%h, required %h/%h/%h/%h/%h at %0t",
                   out_instr, out_rs1, out_rs2, out_track_id, out_vxrm,
                   e.instr, e.rs1, e.rs2, e.tid, e.vxrm, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; vcfg_ack = 1'b0;
    in_instr = 32'h0; in_rs1 = 32'h0; in_rs2 = 32'h0; in_track_id = 4'h0; in_vxrm = 3'b000;

    // Reset behaviour
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b1;
    step();
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Ordering, latency 1, count peaks at 1
    out_ready = 1'b1;
    push(32'h0000_0057);
    #1;
    check("ord_valid_before", 32'(out_valid), 32'd0);
    step();
    check("ord_latency_valid", 32'(out_valid), 32'd1);
    check("ord_count0", 32'(count), 32'd1);
    push(32'h0010_0057);
    step();
    check("ord_count1", 32'(count), 32'd1);
    push(32'h0020_0057);
    step();
    check("ord_count2", 32'(count), 32'd1);
    idle();
    step();
    check("ord_drained", 32'(count), 32'd0);
    check("ord_valid_end", 32'(out_valid), 32'd0);

    // Full boundary
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h0030_0057 + (32'(i) << 20));
      step();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    offer(32'h0070_0057);
    step();
    check("full_held_count", 32'(count), 32'd4);
    check("full_held_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("full_pop_no_push", 32'(count), 32'd3);
    exp_q.push_back(mk(32'h0070_0057));
    step();
    check("full_push_pop", 32'(count), 32'd3);
    idle();
    repeat (3) step();
    check("full_drained", 32'(count), 32'd0);

    // Config fence with vcfg_ack delayed 3 cycles
    out_ready = 1'b0;
    push(32'h0C05_72D7);
    step();
    push(32'h0220_8057);
    step();
    idle();
    check("fence_count2", 32'(count), 32'd2);
    check("fence_head_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("fence_wait1", 32'(out_valid), 32'd0);
    check("fence_count1", 32'(count), 32'd1);
    step();
    check("fence_wait2", 32'(out_valid), 32'd0);
    step();
    check("fence_wait3", 32'(out_valid), 32'd0);
    vcfg_ack = 1'b1;
    step();
    vcfg_ack = 1'b0;
    check("fence_release", 32'(out_valid), 32'd1);
    step();
    check("fence_drained", 32'(count), 32'd0);

    // Flush while fenced at count 3, with a concurrent push offered
    out_ready = 1'b0;
    push(32'h0C05_72D7);
    step();
    push(32'h00A0_0057);
    step();
    push(32'h00B0_0057);
    step();
    check("flush_fill", 32'(count), 32'd3);
    out_ready = 1'b1;
    push(32'h00C0_0057);
    step();
    check("flush_wait_count", 32'(count), 32'd3);
    check("flush_wait_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    offer(32'h00D0_0057);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    idle();
    exp_q.delete();
    #1;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    push(32'h00E0_0057);
    step();
    check("flush_idle_valid", 32'(out_valid), 32'd1);
    idle();
    step();
    check("flush_post_count", 32'(count), 32'd0);

    // Sustained push/pop across pointer wrap, ack toggling in IDLE
    out_ready = 1'b0;
    push(32'h0100_0057);
    step();
    push(32'h0110_0057);
    step();
    check("wrap_prefill", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(32'h0120_0057 + (32'(i) << 20));
      vcfg_ack = (i % 2 == 1);
      step();
      check("wrap_count", 32'(count), 32'd2);
    end
    vcfg_ack = 1'b0;
    idle();
    repeat (2) step();
    check("wrap_drained", 32'(count), 32'd0);
    check("wrap_scoreboard", 32'(exp_q.size()), 32'd0);

    // Mid-operation reset at count 3 while fenced
    out_ready = 1'b0;
    push(32'h0C05_72D7);
    step();
    push(32'h0200_0057);
    step();
    push(32'h0210_0057);
    step();
    out_ready = 1'b1;
    push(32'h0220_0057);
    step();
    out_ready = 1'b0;
    idle();
    check("mrst_count_before", 32'(count), 32'd3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    push(32'h0230_0057);
    step();
    check("mrst_fresh_valid", 32'(out_valid), 32'd1);
    check("mrst_fresh_count", 32'(count), 32'd1);
    idle();
    step();
    check("mrst_drained", 32'(count), 32'd0);

    repeat (3) step();
    check("final_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
